// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: inter-stage bus widths,
// field offsets and the one-hot load-operation bit indices.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_W = 76;
  localparam int MS_TO_WS_BUS_W = 70;

  localparam int LD_OP_W = 5;

  // One-hot ld_op bit positions
  typedef enum int {
    LD_B  = 0,
    LD_H  = 1,
    LD_W  = 2,
    LD_BU = 3,
    LD_HU = 4
  } ld_op_idx_e;

  // Execute-to-memory bus field offsets
  localparam int ES_PC_LSB           = 0;
  localparam int ES_ALU_RESULT_LSB   = 32;
  localparam int ES_DEST_LSB         = 64;
  localparam int ES_GR_WE_BIT        = 69;
  localparam int ES_RES_FROM_MEM_BIT = 70;
  localparam int ES_LD_OP_LSB        = 71;

  // Memory-to-write-back bus field offsets
  localparam int WS_PC_LSB           = 0;
  localparam int WS_FINAL_RESULT_LSB = 32;
  localparam int WS_DEST_LSB         = 64;
  localparam int WS_GR_WE_BIT        = 69;

  // Assemble the write-back bus from its fields
  function automatic logic [MS_TO_WS_BUS_W-1:0] pack_ms_to_ws(
    input logic        gr_we,
    input logic [4:0]  dest,
    input logic [31:0] final_result,
    input logic [31:0] pc
  );
    return {gr_we, dest, final_result, pc};
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: selects the byte or halfword addressed by
// the low address bits and sign- or zero-extends it to 32 bits.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [LD_OP_W-1:0] i_ld_op,
  input  logic [1:0]         i_offset,
  input  logic [31:0]        i_word,
  output logic [31:0]        o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and halfword; halves ignore offset[0]
  always_comb begin
    w_byte = i_word[7:0];
    case (i_offset)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
  end

  // Extend according to the load type; no load bit set means full word
  always_comb begin
    o_data = i_word;
    if (i_ld_op[LD_B])
      o_data = {{24{w_byte[7]}}, w_byte};
    else if (i_ld_op[LD_H])
      o_data = {{16{w_half[15]}}, w_half};
    else if (i_ld_op[LD_BU])
      o_data = {24'd0, w_byte};
    else if (i_ld_op[LD_HU])
      o_data = {16'd0, w_half};
    else if (i_ld_op[LD_W])
      o_data = i_word;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute-stage bus, aligns SRAM
// load data, holds that data stable across write-back stalls, and feeds the
// decode-stage bypass network.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_ws_allowin,
  output logic                      o_ms_allowin,
  input  logic                      i_es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_W-1:0] i_es_to_ms_bus,
  input  logic [31:0]               i_data_sram_rdata,
  output logic                      o_ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_W-1:0] o_ms_to_ws_bus,
  output logic [4:0]                o_ms_to_ds_dest,
  output logic [31:0]               o_ms_to_ds_value
);

  logic                      r_ms_valid;
  logic [ES_TO_MS_BUS_W-1:0] r_es_bus;
  logic                      r_first_cycle;
  logic [31:0]               r_rdata_buf;
  logic                      r_rdata_buf_valid;

  logic                w_ms_ready_go;
  logic                w_ms_allowin;
  logic [LD_OP_W-1:0]  w_ld_op;
  logic                w_res_from_mem;
  logic                w_gr_we;
  logic [4:0]          w_dest;
  logic [31:0]         w_alu_result;
  logic [31:0]         w_pc;
  logic [31:0]         w_load_word;
  logic [31:0]         w_load_data;
  logic [31:0]         w_final_result;
  logic                w_bypass_en;

  assign w_ms_ready_go = 1'b1;
  assign w_ms_allowin  = !r_ms_valid || (w_ms_ready_go && i_ws_allowin);

  assign w_ld_op        = r_es_bus[ES_LD_OP_LSB +: LD_OP_W];
  assign w_res_from_mem = r_es_bus[ES_RES_FROM_MEM_BIT];
  assign w_gr_we        = r_es_bus[ES_GR_WE_BIT];
  assign w_dest         = r_es_bus[ES_DEST_LSB +: 5];
  assign w_alu_result   = r_es_bus[ES_ALU_RESULT_LSB +: 32];
  assign w_pc           = r_es_bus[ES_PC_LSB +: 32];

  // Stage occupancy and bus capture; a bubble keeps the stale bus but clears valid
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ms_valid <= 1'b0;
      r_es_bus   <= '0;
    end else if (w_ms_allowin) begin
      r_ms_valid <= i_es_to_ms_valid;
      if (i_es_to_ms_valid)
        r_es_bus <= i_es_to_ms_bus;
    end
  end

  // Marks the single cycle in which the SRAM is still driving this load's data
  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_first_cycle <= 1'b0;
    else if (w_ms_allowin)
      r_first_cycle <= i_es_to_ms_valid;
    else
      r_first_cycle <= 1'b0;
  end

  // Snapshot live read data when the first cycle ends in a stall; release on departure
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdata_buf       <= '0;
      r_rdata_buf_valid <= 1'b0;
    end else if (w_ms_allowin) begin
      r_rdata_buf_valid <= 1'b0;
    end else if (r_ms_valid && r_first_cycle && !r_rdata_buf_valid) begin
      r_rdata_buf       <= i_data_sram_rdata;
      r_rdata_buf_valid <= 1'b1;
    end
  end

  assign w_load_word = r_rdata_buf_valid ? r_rdata_buf : i_data_sram_rdata;

  load_align u_load_align (
    .i_ld_op  (w_ld_op),
    .i_offset (w_alu_result[1:0]),
    .i_word   (w_load_word),
    .o_data   (w_load_data)
  );

  assign w_final_result = w_res_from_mem ? w_load_data : w_alu_result;
  assign w_bypass_en    = r_ms_valid && w_gr_we;

  assign o_ms_allowin     = w_ms_allowin;
  assign o_ms_to_ws_valid = r_ms_valid && w_ms_ready_go;
  assign o_ms_to_ws_bus   = pack_ms_to_ws(w_gr_we, w_dest, w_final_result, w_pc);
  assign o_ms_to_ds_dest  = {5{w_bypass_en}} & w_dest;
  assign o_ms_to_ds_value = {32{w_bypass_en}} & w_final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues instructions and pushes the
// expected write-back view; a negedge monitor compares whatever the stage shows.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        wsAllowin;
  logic        msAllowin;
  logic        esToMsValid;
  logic [75:0] esToMsBus;
  logic [31:0] sramRdata;
  logic        msToWsValid;
  logic [69:0] msToWsBus;
  logic [4:0]  msToDsDest;
  logic [31:0] msToDsValue;

  typedef struct {
    logic [69:0] wsBus;
    logic        grWe;
    logic [4:0]  dest;
    logic [31:0] result;
  } expT;

  expT         expQ[$];
  logic        pendingValid;
  logic [75:0] pendingBus;
  int          checksPassed;
  int          checksTotal;

  mem_stage dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_ws_allowin     (wsAllowin),
    .o_ms_allowin     (msAllowin),
    .i_es_to_ms_valid (esToMsValid),
    .i_es_to_ms_bus   (esToMsBus),
    .i_data_sram_rdata(sramRdata),
    .o_ms_to_ws_valid (msToWsValid),
    .o_ms_to_ws_bus   (msToWsBus),
    .o_ms_to_ds_dest  (msToDsDest),
    .o_ms_to_ds_value (msToDsValue)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [75:0] mkBus(input logic [4:0] ldOp, input logic resMem,
                                        input logic grWe, input logic [4:0] dest,
                                        input logic [31:0] alu, input logic [31:0] pc);
    return {ldOp, resMem, grWe, dest, alu, pc};
  endfunction

  // Reference result from the load rules, using plain shift/mask arithmetic
  function automatic logic [31:0] refResult(input logic [75:0] bus, input logic [31:0] rdata);
    logic [4:0] ldOp;
    int off;
    int b;
    int h;
    ldOp = bus[75:71];
    off  = int'(bus[33:32]);
    if (!bus[70]) return bus[63:32];
    b = int'((rdata >> (8 * off)) & 32'hFF);
    h = int'((rdata >> (16 * (off / 2))) & 32'hFFFF);
    case (ldOp)
      5'b00001: return (b >= 128) ? 32'(b - 256) : 32'(b);
      5'b00010: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      5'b01000: return 32'(b);
      5'b10000: return 32'(h);
      default:  return rdata;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [69:0] actual, input logic [69:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  // One cycle of stimulus; rdata is what the SRAM returns during this cycle
  task automatic applyStimulus(input logic esValid, input logic [75:0] bus,
                               input logic ws, input logic [31:0] rdata);
    expT e;
    @(posedge clk);
    #1;
    sramRdata = rdata;
    if (pendingValid) begin
      e.grWe   = pendingBus[69];
      e.dest   = pendingBus[68:64];
      e.result = refResult(pendingBus, rdata);
      e.wsBus  = {pendingBus[69], pendingBus[68:64], e.result, pendingBus[31:0]};
      expQ.push_back(e);
      pendingValid = 1'b0;
    end
    esToMsValid = esValid;
    esToMsBus   = bus;
    wsAllowin   = ws;
    if (esValid && ((expQ.size() == 0) || ws)) begin
      pendingValid = 1'b1;
      pendingBus   = bus;
    end
  endtask

  task automatic applyReset(input logic ws);
    @(posedge clk);
    #1;
    reset        = 1'b1;
    esToMsValid  = 1'b0;
    wsAllowin    = ws;
    expQ.delete();
    pendingValid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compare the stage view against the head of the scoreboard
  always @(negedge clk) begin
    expT e;
    if (!reset) begin
      if (expQ.size() == 0) begin
        checkOutput("idle_valid", 70'(msToWsValid), 70'(0));
        checkOutput("idle_allowin", 70'(msAllowin), 70'(1));
        checkOutput("idle_ds_dest", 70'(msToDsDest), 70'(0));
        checkOutput("idle_ds_value", 70'(msToDsValue), 70'(0));
      end else begin
        e = expQ[0];
        checkOutput("ws_valid", 70'(msToWsValid), 70'(1));
        checkOutput("ws_bus", msToWsBus, e.wsBus);
        checkOutput("ds_dest", 70'(msToDsDest), 70'(e.grWe ? e.dest : 5'd0));
        checkOutput("ds_value", 70'(msToDsValue), 70'(e.grWe ? e.result : 32'd0));
        checkOutput("allowin", 70'(msAllowin), 70'(wsAllowin));
        if (wsAllowin) e = expQ.pop_front();
      end
    end
  end

  // Directed cases followed by a randomized run
  initial begin
    logic [4:0] ldChoices[6];
    logic [4:0] op;
    ldChoices = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00000};
    checksPassed = 0;
    checksTotal  = 0;
    pendingValid = 1'b0;
    pendingBus   = '0;
    reset        = 1'b1;
    wsAllowin    = 1'b1;
    esToMsValid  = 1'b0;
    esToMsBus    = '0;
    sramRdata    = '0;
    repeat (2) @(posedge clk);
    applyReset(1'b1);
    applyStimulus(1'b0, '0, 1'b1, 32'h0);

    // ld.b sign-extends the top byte
    applyStimulus(1'b1, mkBus(5'b00001, 1'b1, 1'b1, 5'd7, 32'h1003, 32'h1c00_0000), 1'b1, 32'h0);
    applyStimulus(1'b0, '0, 1'b1, 32'h8012_3456);
    // ld.hu, ld.h at offset 2 and ld.bu at offset 1
    applyStimulus(1'b1, mkBus(5'b10000, 1'b1, 1'b1, 5'd3, 32'h2002, 32'h1c00_0004), 1'b1, 32'h0);
    applyStimulus(1'b1, mkBus(5'b00010, 1'b1, 1'b1, 5'd4, 32'h2002, 32'h1c00_0008), 1'b1, 32'hBEEF_0001);
    applyStimulus(1'b1, mkBus(5'b01000, 1'b1, 1'b1, 5'd9, 32'h3001, 32'h1c00_000c), 1'b1, 32'hBEEF_0001);
    applyStimulus(1'b0, '0, 1'b1, 32'h0000_F000);
    // Stall hold of ld.w while SRAM data changes
    applyStimulus(1'b1, mkBus(5'b00100, 1'b1, 1'b1, 5'd10, 32'h4000, 32'h1c00_0010), 1'b1, 32'h0);
    applyStimulus(1'b1, mkBus(5'b00100, 1'b1, 1'b1, 5'd11, 32'h4004, 32'h1c00_0014), 1'b0, 32'hDEAD_BEEF);
    repeat (2) applyStimulus(1'b1, mkBus(5'b00100, 1'b1, 1'b1, 5'd11, 32'h4004, 32'h1c00_0014), 1'b0, 32'h1111_1111);
    applyStimulus(1'b0, '0, 1'b1, 32'h1111_1111);
    // Non-load with and without register write
    applyStimulus(1'b1, mkBus(5'b00000, 1'b0, 1'b1, 5'd5, 32'h42, 32'h1c00_0018), 1'b1, 32'h5555_5555);
    applyStimulus(1'b1, mkBus(5'b00000, 1'b0, 1'b0, 5'd5, 32'h42, 32'h1c00_001c), 1'b1, 32'h6666_6666);
    applyStimulus(1'b0, '0, 1'b1, 32'h7777_7777);
    // Back-to-back loads each see their own read data
    applyStimulus(1'b1, mkBus(5'b00100, 1'b1, 1'b1, 5'd12, 32'h5000, 32'h1c00_0020), 1'b1, 32'h0);
    applyStimulus(1'b1, mkBus(5'b00100, 1'b1, 1'b1, 5'd13, 32'h5004, 32'h1c00_0024), 1'b1, 32'hAAAA_0001);
    applyStimulus(1'b0, '0, 1'b1, 32'hBBBB_0002);
    // Reset arriving during a two-cycle stall
    applyStimulus(1'b1, mkBus(5'b00100, 1'b1, 1'b1, 5'd14, 32'h6000, 32'h1c00_0028), 1'b1, 32'h0);
    applyStimulus(1'b0, '0, 1'b0, 32'hCAFE_0001);
    applyStimulus(1'b0, '0, 1'b0, 32'hCAFE_0002);
    applyReset(1'b0);
    applyStimulus(1'b0, '0, 1'b1, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      op = ldChoices[$urandom_range(5)];
      applyStimulus(($urandom_range(9) < 7) ? 1'b1 : 1'b0,
                    mkBus(op, 1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom),
                          $urandom, $urandom),
                    ($urandom_range(9) < 6) ? 1'b1 : 1'b0,
                    $urandom);
      if (i == 200) applyReset(1'($urandom_range(1)));
    end
    applyStimulus(1'b0, '0, 1'b1, $urandom);
    applyStimulus(1'b0, '0, 1'b1, $urandom);
    @(posedge clk);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
